ddr3_frame_buf_arb: RTL and testbench
=====================================

Name: ddr3_frame_buf_arb

Overview:
- Parametrised successor to the single ping-pong DDR3 read/write controller.
- Manages an N-page frame buffer ring in DDR3 for one write stream (camera side) and one read stream (display side).
- Arbitrates burst requests between the streams, computes page-based addresses, and trims the final burst of a frame.
- Sits between the wfifo/rfifo pair and the DDR3 user-port burst engine.

Parameters:
- ADDR_W, 28, DDR3 word address width.
- LEN_W, 10, burst length width.
- CNT_W, 11, FIFO fill-count width.
- PAGES, 3, number of frame pages in the ring (legal 1..4). 1 means no buffering.
- PAGE_LSB, 24, address bit where the page index starts.
- RFIFO_DEPTH, 1024, rfifo capacity in words.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ddr3_init_done  in  1  DDR3 calibration complete.
- frame_words  in  ADDR_W  words per frame (quasi-static; registered once).
- burst_len  in  LEN_W  nominal burst length, nonzero (quasi-static; registered once).
- wfifo_rcount  in  CNT_W  words available in the write FIFO.
- rfifo_wcount  in  CNT_W  words held in the read FIFO.
- wr_load  in  1  write-source frame start, asynchronous level.
- rd_load  in  1  read-sink frame start, asynchronous level.
- wr_req  out  1  write burst request.
- wr_addr  out  ADDR_W  write burst word address.
- wr_len  out  LEN_W  write burst length.
- wr_finish  in  1  write burst done, one-cycle pulse.
- rd_req  out  1  read burst request.
- rd_addr  out  ADDR_W  read burst word address.
- rd_len  out  LEN_W  read burst length.
- rd_finish  in  1  read burst done, one-cycle pulse.
- rd_page_valid  out  1  at least one complete frame is present in DDR3.
- wr_page_o  out  2  page currently being written.
- rd_page_o  out  2  page currently being read.

Behaviour:
- Reset values: all outputs 0; state IDLE; offsets 0; pending flags 0.
- Input capture: wr_load and rd_load are 2-flop synchronised, then rising-edge detected. frame_words and burst_len are registered once.
- FSM IDLE -> ARB when ddr3_init_done=1.
- wr_go = wr_active && wfifo_rcount >= wr_len_n, where wr_len_n = min(burst_len, frame_words - wr_off).
- rd_go = rd_active && rd_page_valid && rfifo_wcount <= RFIFO_DEPTH - rd_len_n, where rd_len_n is defined the same way on rd_off.
- ARB: apply any pending load first, with no grant that cycle. Otherwise grant WRITE if wr_go, else READ if rd_go, else stay in ARB.
- WRITE / READ:
  - On entry, latch addr = (page << PAGE_LSB) | offset and len = the trimmed length.
  - Assert req from the cycle after entry until the finish pulse. addr and len stay stable while req=1.
  - On finish: req drops the same edge; offset += len; return to ARB.
- Write frame end (wr_off reaches frame_words):
  - Offset wraps to 0; completed page is recorded as last_done; rd_page_valid is set.
  - wr_page advances to (wr_page+1) mod PAGES, skipping rd_page when PAGES >= 3.
- wr_load edge:
  - First one sets wr_active.
  - Each one zeroes wr_off; the partial frame is discarded and last_done is unchanged.
  - If the edge arrives in WRITE, it is held pending and applied in ARB after finish.
- rd_load edge: sets rd_active, zeroes rd_off, sets rd_page = last_done. Pending rules are the same as for wr_load.
- Read wrap (rd_off reaches frame_words): rd_off goes to 0 and the same page is re-read until the next rd_load.
- PAGES=1: page index is forced to 0 and rd_page_valid is set after the first complete frame.
- Simultaneous events:
  - wr and rd load edges in the same cycle are both applied.
  - A finish pulse and a load edge in the same cycle: finish updates the offset first, then the pending load applies in ARB.
- Error cases:
  - Finish pulses while not in the matching state are ignored.
  - ddr3_init_done falling: finish any in-flight burst, then go to IDLE with offsets retained.
- Arithmetic: offsets are ADDR_W wide with compares unsigned. If frame_words=0, both streams stay inactive.

Optional Feature:
- Macro DDR3_RR_ARB_EN.
- Defined: ARB uses round-robin. When both wr_go and rd_go are true, the stream not granted last wins. The last-grant flag resets to "read", so write wins the first tie.
- Undefined: fixed write priority, as described in Behaviour.

Test Plan:
- Reset, then init_done=1, frame_words=64, burst_len=16, wr_load edge, wfifo_rcount=16 -> wr_req with wr_addr 0x0000000, wr_len 16. Four finishes -> rd_page_valid=1, wr_page_o=1.
- frame_words=40, burst_len=16 -> write lengths 16, 16, 8; offsets 0, 16, 32; then wrap.
- PAGES=3, reader holds page 1, writer completes page 0 -> wr_page_o skips 1 and goes to 2 (addr base 0x2000000).
- wr_load edge mid-burst at offset 32 -> burst completes at len 16, then next wr_addr offset is 0 and last_done is unchanged.
- Both streams ready continuously: without macro, WRITE is always granted; with DDR3_RR_ARB_EN, grants alternate W, R, W, R.
- rfifo_wcount=1010, RFIFO_DEPTH=1024, burst_len=16 -> no rd_req. At 1008 -> rd_req with rd_len 16.

Source files
------------

// File: rtl/ddr3_frame_buf_arb.sv
// ddr3_frame_buf_arb: N-page DDR3 frame-buffer ring arbiter for one write
// stream and one read stream. It computes page-based burst addresses, trims
// the final burst of each frame and tracks which page holds the newest frame.
// Optional feature macro: DDR3_RR_ARB_EN (round-robin instead of write priority).
module ddr3_frame_buf_arb #(
  parameter int ADDR_W      = 28,
  parameter int LEN_W       = 10,
  parameter int CNT_W       = 11,
  parameter int PAGES       = 3,
  parameter int PAGE_LSB    = 24,
  parameter int RFIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ddr3_init_done,
  input  logic [ADDR_W-1:0] frame_words,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  input  logic              wr_finish,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_finish,
  output logic              rd_page_valid,
  output logic [1:0]        wr_page_o,
  output logic [1:0]        rd_page_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_WRITE, ST_READ} state_e;

  state_e            state_q, state_d;
  logic [2:0]        wr_load_sync_q, wr_load_sync_d;
  logic [2:0]        rd_load_sync_q, rd_load_sync_d;
  logic [ADDR_W-1:0] fw_q, fw_d;
  logic [LEN_W-1:0]  bl_q, bl_d;
  logic              wr_active_q, wr_active_d;
  logic              rd_active_q, rd_active_d;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d;
  logic [ADDR_W-1:0] rd_off_q, rd_off_d;
  logic [1:0]        wr_page_q, wr_page_d;
  logic [1:0]        rd_page_q, rd_page_d;
  logic [1:0]        last_done_q, last_done_d;
  logic              rd_page_valid_q, rd_page_valid_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  wr_len_q, wr_len_d;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
`ifdef DDR3_RR_ARB_EN
  logic              last_wr_q, last_wr_d;
`endif

  logic              wr_edge, rd_edge;
  logic [LEN_W-1:0]  wr_len_n, rd_len_n;
  logic              wr_go, rd_go;
  logic              grant_wr, grant_rd;
  logic [ADDR_W-1:0] wr_sum, rd_sum;
  logic [1:0]        wr_page_step, wr_page_adv;

  function automatic logic [1:0] next_page(input logic [1:0] p);
    if (PAGES <= 1) return 2'd0;
    else if (p >= 2'(PAGES - 1)) return 2'd0;
    else return p + 2'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] page_base(input logic [1:0] p);
    return ADDR_W'(p) << PAGE_LSB;
  endfunction

  // Burst length clipped to what is left of the frame.
  function automatic logic [LEN_W-1:0] trim_len(input logic [ADDR_W-1:0] fw,
                                                input logic [ADDR_W-1:0] off,
                                                input logic [LEN_W-1:0]  bl);
    logic [ADDR_W-1:0] rem;
    rem = fw - off;
    if (rem < ADDR_W'(bl)) return rem[LEN_W-1:0];
    return bl;
  endfunction

  assign wr_edge  = wr_load_sync_q[1] & ~wr_load_sync_q[2];
  assign rd_edge  = rd_load_sync_q[1] & ~rd_load_sync_q[2];
  assign wr_len_n = trim_len(fw_q, wr_off_q, bl_q);
  assign rd_len_n = trim_len(fw_q, rd_off_q, bl_q);
  assign wr_go    = wr_active_q && (wr_len_n != '0) &&
                    (32'(wfifo_rcount) >= 32'(wr_len_n));
  // Room check written as count + len <= depth so nothing can underflow.
  assign rd_go    = rd_active_q && rd_page_valid_q && (rd_len_n != '0) &&
                    ((32'(rfifo_wcount) + 32'(rd_len_n)) <= 32'(RFIFO_DEPTH));
  assign wr_sum   = wr_off_q + ADDR_W'(wr_len_q);
  assign rd_sum   = rd_off_q + ADDR_W'(rd_len_q);

  // Writer never lands on the page being displayed when the ring has room to skip it.
  assign wr_page_step = next_page(wr_page_q);
  assign wr_page_adv  = (PAGES >= 3 && wr_page_step == rd_page_q) ?
                        next_page(wr_page_step) : wr_page_step;

  // Grant selection: fixed write priority or round-robin on ties.
  always_comb begin
`ifdef DDR3_RR_ARB_EN
    grant_wr = wr_go && (!rd_go || !last_wr_q);
    grant_rd = rd_go && !grant_wr;
`else
    grant_wr = wr_go;
    grant_rd = rd_go && !wr_go;
`endif
  end

  // Next-state, offsets, page bookkeeping and burst outputs.
  always_comb begin
    state_d         = state_q;
    wr_load_sync_d  = {wr_load_sync_q[1:0], wr_load};
    rd_load_sync_d  = {rd_load_sync_q[1:0], rd_load};
    fw_d            = frame_words;
    bl_d            = burst_len;
    wr_active_d     = wr_active_q;
    rd_active_d     = rd_active_q;
    wr_off_d        = wr_off_q;
    rd_off_d        = rd_off_q;
    wr_page_d       = wr_page_q;
    rd_page_d       = rd_page_q;
    last_done_d     = last_done_q;
    rd_page_valid_d = rd_page_valid_q;
    wr_pend_d       = wr_pend_q | wr_edge;
    rd_pend_d       = rd_pend_q | rd_edge;
    wr_req_d        = wr_req_q;
    rd_req_d        = rd_req_q;
    wr_addr_d       = wr_addr_q;
    rd_addr_d       = rd_addr_q;
    wr_len_d        = wr_len_q;
    rd_len_d        = rd_len_q;
`ifdef DDR3_RR_ARB_EN
    last_wr_d       = last_wr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (ddr3_init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!ddr3_init_done) begin
          state_d = ST_IDLE;
        end else if (wr_pend_d || rd_pend_d) begin
          // Frame-start loads take the whole cycle; arbitration resumes next cycle.
          if (wr_pend_d) begin
            wr_active_d = (fw_q != '0);
            wr_off_d    = '0;
            wr_pend_d   = 1'b0;
          end
          if (rd_pend_d) begin
            rd_active_d = (fw_q != '0);
            rd_off_d    = '0;
            rd_page_d   = last_done_q;
            rd_pend_d   = 1'b0;
          end
        end else if (grant_wr) begin
          state_d   = ST_WRITE;
          wr_addr_d = page_base(wr_page_q) | wr_off_q;
          wr_len_d  = wr_len_n;
`ifdef DDR3_RR_ARB_EN
          last_wr_d = 1'b1;
`endif
        end else if (grant_rd) begin
          state_d   = ST_READ;
          rd_addr_d = page_base(rd_page_q) | rd_off_q;
          rd_len_d  = rd_len_n;
`ifdef DDR3_RR_ARB_EN
          last_wr_d = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        if (wr_finish) begin
          wr_req_d = 1'b0;
          state_d  = ST_ARB;
          if (wr_sum >= fw_q) begin
            wr_off_d        = '0;
            last_done_d     = wr_page_q;
            rd_page_valid_d = 1'b1;
            wr_page_d       = wr_page_adv;
          end else begin
            wr_off_d = wr_sum;
          end
        end else begin
          wr_req_d = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_finish) begin
          rd_req_d = 1'b0;
          state_d  = ST_ARB;
          rd_off_d = (rd_sum >= fw_q) ? '0 : rd_sum;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wr_load_sync_q  <= '0;
      rd_load_sync_q  <= '0;
      fw_q            <= '0;
      bl_q            <= '0;
      wr_active_q     <= 1'b0;
      rd_active_q     <= 1'b0;
      wr_off_q        <= '0;
      rd_off_q        <= '0;
      wr_page_q       <= '0;
      rd_page_q       <= '0;
      last_done_q     <= '0;
      rd_page_valid_q <= 1'b0;
      wr_pend_q       <= 1'b0;
      rd_pend_q       <= 1'b0;
      wr_req_q        <= 1'b0;
      rd_req_q        <= 1'b0;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      wr_len_q        <= '0;
      rd_len_q        <= '0;
`ifdef DDR3_RR_ARB_EN
      last_wr_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      wr_load_sync_q  <= wr_load_sync_d;
      rd_load_sync_q  <= rd_load_sync_d;
      fw_q            <= fw_d;
      bl_q            <= bl_d;
      wr_active_q     <= wr_active_d;
      rd_active_q     <= rd_active_d;
      wr_off_q        <= wr_off_d;
      rd_off_q        <= rd_off_d;
      wr_page_q       <= wr_page_d;
      rd_page_q       <= rd_page_d;
      last_done_q     <= last_done_d;
      rd_page_valid_q <= rd_page_valid_d;
      wr_pend_q       <= wr_pend_d;
      rd_pend_q       <= rd_pend_d;
      wr_req_q        <= wr_req_d;
      rd_req_q        <= rd_req_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      wr_len_q        <= wr_len_d;
      rd_len_q        <= rd_len_d;
`ifdef DDR3_RR_ARB_EN
      last_wr_q       <= last_wr_d;
`endif
    end
  end

  assign wr_req        = wr_req_q;
  assign wr_addr       = wr_addr_q;
  assign wr_len        = wr_len_q;
  assign rd_req        = rd_req_q;
  assign rd_addr       = rd_addr_q;
  assign rd_len        = rd_len_q;
  assign rd_page_valid = rd_page_valid_q;
  assign wr_page_o     = wr_page_q;
  assign rd_page_o     = rd_page_q;

endmodule

// File: tb/tb_ddr3_frame_buf_arb.sv
// Directed bench for ddr3_frame_buf_arb (default parameters, PAGES=3).
module tb_ddr3_frame_buf_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ddr3_init_done;
  logic [27:0] frame_words;
  logic [9:0]  burst_len;
  logic [10:0] wfifo_rcount, rfifo_wcount;
  logic        wr_load, rd_load, wr_finish, rd_finish;
  logic        wr_req, rd_req, rd_page_valid;
  logic [27:0] wr_addr, rd_addr;
  logic [9:0]  wr_len, rd_len;
  logic [1:0]  wr_page_o, rd_page_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr3_frame_buf_arb #(
    .ADDR_W(28), .LEN_W(10), .CNT_W(11), .PAGES(3), .PAGE_LSB(24), .RFIFO_DEPTH(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ddr3_init_done(ddr3_init_done),
    .frame_words(frame_words), .burst_len(burst_len),
    .wfifo_rcount(wfifo_rcount), .rfifo_wcount(rfifo_wcount),
    .wr_load(wr_load), .rd_load(rd_load),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_finish(wr_finish),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_finish(rd_finish),
    .rd_page_valid(rd_page_valid), .wr_page_o(wr_page_o), .rd_page_o(rd_page_o)
  );

  typedef struct {
    logic [27:0] addr;
    logic [9:0]  len;
    logic [1:0]  page;
    logic        valid;
    int          act;
  } wrow_t;

  wrow_t tbl[17];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input bit is_rd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((is_rd ? rd_req : wr_req) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no request expected request", is_rd ? "rd_req" : "wr_req");
    end
  endtask

  task automatic wait_any(output int which);
    which = -1;
    for (int i = 0; i < 200; i++) begin
      if (wr_req === 1'b1) begin which = 0; break; end
      if (rd_req === 1'b1) begin which = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic finish_wr();
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    check("wr_req_drop", 32'(wr_req), 0);
  endtask

  task automatic finish_rd();
    rd_finish = 1'b1;
    tick();
    rd_finish = 1'b0;
    check("rd_req_drop", 32'(rd_req), 0);
  endtask

  task automatic pulse_wr_load();
    wr_load = 1'b1;
    repeat (4) tick();
    wr_load = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_rd_load();
    rd_load = 1'b1;
    repeat (4) tick();
    rd_load = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    bit          ok;
    int          which;
    int          cnt;
    int          exp_g[4];
    logic [27:0] exp_rd_off;
    logic [27:0] exp_resume;

    // Write bursts: act 1 = drain wfifo before finish, 2 = rd_load mid-burst,
    // 3 = wr_load mid-burst, 4 = open rfifo and rd_load mid-burst.
    tbl[0]  = '{28'h0000000, 10'd16, 2'd0, 1'b0, 0};
    tbl[1]  = '{28'h0000010, 10'd16, 2'd0, 1'b0, 0};
    tbl[2]  = '{28'h0000020, 10'd16, 2'd0, 1'b0, 0};
    tbl[3]  = '{28'h0000030, 10'd16, 2'd1, 1'b1, 1};
    tbl[4]  = '{28'h1000000, 10'd16, 2'd1, 1'b1, 0};
    tbl[5]  = '{28'h1000010, 10'd16, 2'd1, 1'b1, 0};
    tbl[6]  = '{28'h1000020, 10'd8,  2'd2, 1'b1, 0};
    tbl[7]  = '{28'h2000000, 10'd16, 2'd2, 1'b1, 2};
    tbl[8]  = '{28'h2000010, 10'd16, 2'd2, 1'b1, 0};
    tbl[9]  = '{28'h2000020, 10'd8,  2'd0, 1'b1, 0};
    tbl[10] = '{28'h0000000, 10'd16, 2'd0, 1'b1, 0};
    tbl[11] = '{28'h0000010, 10'd16, 2'd0, 1'b1, 0};
    tbl[12] = '{28'h0000020, 10'd8,  2'd2, 1'b1, 1};
    tbl[13] = '{28'h2000000, 10'd16, 2'd2, 1'b1, 0};
    tbl[14] = '{28'h2000010, 10'd16, 2'd2, 1'b1, 0};
    tbl[15] = '{28'h2000020, 10'd16, 2'd2, 1'b1, 3};
    tbl[16] = '{28'h2000000, 10'd16, 2'd2, 1'b1, 4};

`ifdef DDR3_RR_ARB_EN
    exp_g      = '{1, 0, 1, 0};
    exp_resume = 28'h2000030;
`else
    exp_g      = '{0, 0, 0, 0};
    exp_resume = 28'h1000010;
`endif

    rst_n = 1'b0; ddr3_init_done = 1'b0;
    frame_words = 28'd64; burst_len = 10'd16;
    wfifo_rcount = 11'd16; rfifo_wcount = 11'd1024;
    wr_load = 1'b0; rd_load = 1'b0; wr_finish = 1'b0; rd_finish = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_wr_req", 32'(wr_req), 0);
    check("rst_rd_req", 32'(rd_req), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_len", 32'(wr_len), 0);
    check("rst_valid", 32'(rd_page_valid), 0);
    check("rst_wr_page", 32'(wr_page_o), 0);
    check("rst_rd_page", 32'(rd_page_o), 0);

    // Load edge while calibration is pending stays pending; no request in IDLE.
    pulse_wr_load();
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wr_req) cnt++;
    end
    check("idle_no_req", 32'(cnt), 0);
    ddr3_init_done = 1'b1;

    for (int i = 0; i < 17; i++) begin
      wait_req(1'b0, ok);
      if (ok) begin
        check($sformatf("wr_addr_%0d", i), 32'(wr_addr), 32'(tbl[i].addr));
        check($sformatf("wr_len_%0d", i), 32'(wr_len), 32'(tbl[i].len));
      end
      case (tbl[i].act)
        1: wfifo_rcount = 11'd0;
        2: pulse_rd_load();
        3: pulse_wr_load();
        4: begin rfifo_wcount = 11'd0; pulse_rd_load(); end
        default: ;
      endcase
      finish_wr();
      check($sformatf("wr_page_%0d", i), 32'(wr_page_o), 32'(tbl[i].page));
      check($sformatf("valid_%0d", i), 32'(rd_page_valid), 32'(tbl[i].valid));
      if (i == 3) begin
        frame_words = 28'd40;
        repeat (3) tick();
        wfifo_rcount = 11'd16;
      end
      if (i == 7) begin
        repeat (2) tick();
        check("rd_page_after_load", 32'(rd_page_o), 1);
      end
      if (i == 12) begin
        frame_words = 28'd64;
        repeat (3) tick();
        wfifo_rcount = 11'd16;
      end
    end

    // Both streams ready: grant order depends on arbitration mode.
    exp_rd_off = '0;
    for (int i = 0; i < 4; i++) begin
      wait_any(which);
      check($sformatf("grant_%0d", i), 32'(which), 32'(exp_g[i]));
      if (i == 0) check("rd_page_last_done", 32'(rd_page_o), 0);
      if (i == 3) begin
        wfifo_rcount = 11'd0;
        rfifo_wcount = 11'd1010;
      end
      if (which == 1) begin
        check($sformatf("rd_addr_%0d", i), 32'(rd_addr), 32'(exp_rd_off));
        check($sformatf("rd_len_%0d", i), 32'(rd_len), 16);
        exp_rd_off = exp_rd_off + 28'd16;
        finish_rd();
      end else if (which == 0) begin
        finish_wr();
      end
    end

    // rfifo room boundary; stray rd_finish in ARB is ignored.
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      rd_finish = (k == 10);
      tick();
      if (rd_req || wr_req) cnt++;
    end
    rd_finish = 1'b0;
    check("rfifo_1010_no_req", 32'(cnt), 0);
    rfifo_wcount = 11'd1008;
    wait_req(1'b1, ok);
    if (ok) begin
      check("rfifo_1008_addr", 32'(rd_addr), 32'(exp_rd_off));
      check("rfifo_1008_len", 32'(rd_len), 16);
    end
    finish_rd();

    // Calibration loss parks the arbiter; offsets survive.
    ddr3_init_done = 1'b0;
    rfifo_wcount = 11'd1024;
    wfifo_rcount = 11'd16;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rd_req || wr_req) cnt++;
    end
    check("init_low_no_req", 32'(cnt), 0);
    ddr3_init_done = 1'b1;
    wait_req(1'b0, ok);
    if (ok) check("resume_wr_addr", 32'(wr_addr), 32'(exp_resume));
    finish_wr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
